// File: rtl/pipe_stage_reg.sv
// Generic pipeline-boundary register with a 2-entry skid buffer (registered in_ready), flush and ctrl squashing.
// Optional stall counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_stage_reg #(
  parameter int PAYLOAD_W = 101,
  parameter int CTRL_W    = 3,
  parameter int PC_W      = 32,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [CTRL_W-1:0]    in_ctrl,
  input  logic [PC_W-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CTRL_W-1:0]    out_ctrl,
  output logic [PC_W-1:0]      out_pc
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]     stall_cnt
`endif
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  if (PAYLOAD_W < 1 || CTRL_W < 1 || PC_W < 1 || CNT_W < 1) begin : g_bad_params
    $error("pipe_stage_reg: all widths must be at least 1");
  end

  logic [1:0]           r_state;
  logic                 r_in_ready;
  logic [PAYLOAD_W-1:0] r_main_payload;
  logic [CTRL_W-1:0]    r_main_ctrl;
  logic [PC_W-1:0]      r_main_pc;
  logic [PAYLOAD_W-1:0] r_skid_payload;
  logic [CTRL_W-1:0]    r_skid_ctrl;
  logic [PC_W-1:0]      r_skid_pc;

  logic       w_out_valid;
  logic       w_accept;
  logic       w_drain;
  logic [1:0] w_state_nxt;
  logic       w_load_main_in;
  logic       w_load_main_skid;
  logic       w_load_skid;

  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_accept    = in_valid & r_in_ready;
  assign w_drain     = w_out_valid & out_ready;

  // Flush overrides every transition; the upstream entry of that cycle is dropped.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt    = ST_ONE;
            w_load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          case ({w_accept, w_drain})
            2'b10: begin
              w_state_nxt = ST_FULL;
              w_load_skid = 1'b1;
            end
            2'b11: begin
              w_state_nxt    = ST_ONE;
              w_load_main_in = 1'b1;
            end
            2'b01:   w_state_nxt = ST_EMPTY;
            default: w_state_nxt = ST_ONE;
          endcase
        end
        ST_FULL: begin
          if (w_drain) begin
            w_state_nxt      = ST_ONE;
            w_load_main_skid = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_EMPTY;
      r_in_ready     <= 1'b1;
      r_main_payload <= '0;
      r_main_ctrl    <= '0;
      r_main_pc      <= '0;
      r_skid_payload <= '0;
      r_skid_ctrl    <= '0;
      r_skid_pc      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_FULL);
      if (w_load_main_in) begin
        r_main_payload <= in_payload;
        r_main_ctrl    <= in_ctrl;
        r_main_pc      <= in_pc;
      end else if (w_load_main_skid) begin
        r_main_payload <= r_skid_payload;
        r_main_ctrl    <= r_skid_ctrl;
        r_main_pc      <= r_skid_pc;
      end else if (flush) begin
        r_main_ctrl    <= '0;
      end
      if (w_load_skid) begin
        r_skid_payload <= in_payload;
        r_skid_ctrl    <= in_ctrl;
        r_skid_pc      <= in_pc;
      end else if (flush) begin
        r_skid_ctrl    <= '0;
      end
    end
  end

  // Bubbles never carry control, whatever the main register happens to hold.
  assign in_ready    = r_in_ready;
  assign out_valid   = w_out_valid;
  assign out_payload = r_main_payload;
  assign out_pc      = r_main_pc;
  assign out_ctrl    = w_out_valid ? r_main_ctrl : '0;

`ifdef PIPE_STALL_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] r_stall_cnt;

  // Saturating count of cycles a valid entry waits on downstream; flush does not clear it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_out_valid && !out_ready && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  a_bubble_no_ctrl: assert property (@(posedge clk) disable iff (reset) !out_valid |-> (out_ctrl == '0));
  a_full_not_ready: assert property (@(posedge clk) disable iff (reset) (r_state == ST_FULL) |-> !in_ready);
  a_state_legal:    assert property (@(posedge clk) disable iff (reset) r_state != 2'd3);

endmodule
